// File: rtl/asteroid_field_ctrl_if.sv
// asteroid_field_ctrl_if
// Bundles the frame-timing inputs and per-slot sprite outputs that pass
// between the asteroid field controller and the renderer.
//   halt        collision freeze from the game logic
//   vaddress    current VGA line
//   haddress    current VGA pixel
//   random1     random value from the rng block
//   frame_tick  one-cycle pulse per frame
//   xpos/ypos   slot i position in bits [10i+9:10i]
//   active      slot i is not IDLE
//   exploding   slot i is in EXPLODE
// Modports: slave = the controller, master = the renderer/game side.
interface asteroid_field_ctrl_if #(
    parameter int NUM_SLOTS = 3
);
    logic                      halt;
    logic [9:0]                vaddress;
    logic [9:0]                haddress;
    logic [4:0]                random1;
    logic                      frame_tick;
    logic [10*NUM_SLOTS-1:0]   xpos;
    logic [10*NUM_SLOTS-1:0]   ypos;
    logic [NUM_SLOTS-1:0]      active;
    logic [NUM_SLOTS-1:0]      exploding;

    modport slave (
        input  halt, vaddress, haddress, random1,
        output frame_tick, xpos, ypos, active, exploding
    );

    modport master (
        output halt, vaddress, haddress, random1,
        input  frame_tick, xpos, ypos, active, exploding
    );
endinterface

// File: rtl/asteroid_field_ctrl.sv
// asteroid_field_ctrl
// Frame-synchronous spawn/fall/explode controller for NUM_SLOTS falling
// asteroids. All slot state advances only in an update cycle, i.e. a cycle
// where frame_tick is high and halt is low.
// Ports:
//   clk    pixel clock
//   reset  synchronous active-high game restart (dominates halt)
//   bus    asteroid_field_ctrl_if.slave (timing inputs, slot outputs)
//
// Slot states:
//   state     | meaning
//   S_IDLE    | slot free, x/y hold, waits for a spawn
//   S_FALL    | y advances FALL_STEP per update until Y_FLOOR
//   S_EXPLODE | landed, fire sprite shown for EXPLODE_FRAMES updates
module asteroid_field_ctrl #(
    parameter int NUM_SLOTS      = 3,
    parameter int SPAWN_GAP      = 40,
    parameter int FALL_STEP      = 2,
    parameter int Y_FLOOR        = 247,
    parameter int X_BASE         = 200,
    parameter int X_SCALE        = 13,
    parameter int EXPLODE_FRAMES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    asteroid_field_ctrl_if.slave bus
);
    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int SC_W  = $clog2(SPAWN_GAP + 1);
    localparam int EC_W  = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FALL    = 2'd1,
        S_EXPLODE = 2'd2
    } slot_state_t;

    slot_state_t      state_q [NUM_SLOTS];
    slot_state_t      state_d [NUM_SLOTS];
    logic [9:0]       x_q     [NUM_SLOTS];
    logic [9:0]       x_d     [NUM_SLOTS];
    logic [9:0]       y_q     [NUM_SLOTS];
    logic [9:0]       y_d     [NUM_SLOTS];
    logic [EC_W-1:0]  ecnt_q  [NUM_SLOTS];
    logic [EC_W-1:0]  ecnt_d  [NUM_SLOTS];
    logic [SC_W-1:0]  spawn_cnt_q, spawn_cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             frame_tick_q;
    logic             update;
    logic [9:0]       spawn_x;
    logic [10:0]      y_sum;

    assign update  = frame_tick_q && !bus.halt;
    // random1 max 31 gives 200 + 31*13 = 603, which fits in 10 bits.
    assign spawn_x = 10'(X_BASE) + 10'(bus.random1) * 10'(X_SCALE);

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_tick_q <= 1'b0;
            spawn_cnt_q  <= SC_W'(SPAWN_GAP);
            ptr_q        <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= S_IDLE;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                ecnt_q[i]  <= '0;
            end
        end else begin
            frame_tick_q <= (bus.vaddress == 10'd480) && (bus.haddress == 10'd0);
            spawn_cnt_q  <= spawn_cnt_d;
            ptr_q        <= ptr_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                ecnt_q[i]  <= ecnt_d[i];
            end
        end
    end

    always_comb begin
        spawn_cnt_d = spawn_cnt_q;
        ptr_d       = ptr_q;
        y_sum       = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            ecnt_d[i]  = ecnt_q[i];
        end

        if (update) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                case (state_q[i])
                    S_FALL: begin
                        // 11-bit sum so a y near 1023 cannot wrap past the floor.
                        y_sum = {1'b0, y_q[i]} + 11'(FALL_STEP);
                        if (y_sum >= 11'(Y_FLOOR)) begin
                            y_d[i]     = 10'(Y_FLOOR);
                            state_d[i] = S_EXPLODE;
                            ecnt_d[i]  = EC_W'(EXPLODE_FRAMES - 1);
                        end else begin
                            y_d[i] = y_sum[9:0];
                        end
                    end
                    S_EXPLODE: begin
                        if (ecnt_q[i] == '0) begin
                            state_d[i] = S_IDLE;
                            y_d[i]     = '0;
                        end else begin
                            ecnt_d[i] = ecnt_q[i] - EC_W'(1);
                        end
                    end
                    default: ;
                endcase
            end

            // Spawn only into a slot that was IDLE before this update, so a
            // slot just leaving EXPLODE waits for the next update.
            if (spawn_cnt_q != '0) begin
                spawn_cnt_d = spawn_cnt_q - SC_W'(1);
            end else begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (PTR_W'(i) == ptr_q && state_q[i] == S_IDLE) begin
                        state_d[i]  = S_FALL;
                        x_d[i]      = spawn_x;
                        y_d[i]      = '0;
                        spawn_cnt_d = SC_W'(SPAWN_GAP);
                        ptr_d       = (ptr_q == PTR_W'(NUM_SLOTS - 1)) ? '0
                                                                       : ptr_q + PTR_W'(1);
                    end
                end
            end
        end
    end

    assign bus.frame_tick = frame_tick_q;

    always_comb begin
        bus.xpos      = '0;
        bus.ypos      = '0;
        bus.active    = '0;
        bus.exploding = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            bus.xpos[10*i +: 10] = x_q[i];
            bus.ypos[10*i +: 10] = y_q[i];
            bus.active[i]        = (state_q[i] != S_IDLE);
            bus.exploding[i]     = (state_q[i] == S_EXPLODE);
        end
    end
endmodule
